keypad_scan_debounce: RTL
=========================

// Module: keypad_scan_debounce
// PURPOSE
// - Active side of the 4x4 matrix keypad interface: drives one column low at a time and reads the rows.
// - Decodes the pressed key to a hex code and debounces both press and release.
// - Emits exactly one key_valid strobe per physical press.
// - Sits between the row synchronizer and the two-digit keypress store; runs on the 48 MHz clock,
//   paced by a scan-rate tick strobe.
// PARAMETERS
// - DEBOUNCE_TICKS  3  consecutive stable ticks required to accept a press or a release (>=1, <=255)
// PORTS
// - clk        in   1  system clock, 48 MHz
// - reset      in   1  asynchronous, active-low reset
// - tick       in   1  1-cycle scan strobe (~1 kHz); all FSM activity advances only on tick
// - row        in   4  synchronized row inputs, active-low (pulled up; 0 = key closes row to driven column)
// - col        out  4  column drive, active-low one-hot; exactly one bit 0 at all times
// - key_code   out  4  hex value of last accepted key; held until next accepted key
// - key_valid  out  1  1-cycle pulse, same cycle key_code updates
// - key_held   out  1  high from acceptance until release debounce completes
// BEHAVIOUR
// - Reset (async assert, sync-free release): state=SCAN, col=4'b1110, cnt=0, key_code=0,
//   key_valid=0, key_held=0.
// - Between ticks all registers hold; key_valid is 0 on every non-accept cycle.
// - Rows are sampled on tick, meaning the column has been driven for one full tick period (settling).
// - SCAN, on tick:
//   - row==4'b1111: rotate col to next column (1110->1101->1011->0111->1110).
//   - exactly one row low: latch row_l=row and col index; col frozen; cnt=1; go DEBOUNCE.
//   - two or more rows low (ghost/multi-key): treat as no press; rotate col.
// - DEBOUNCE, on tick:
//   - row==row_l: cnt++.
//   - any other row value: cnt=0, rotate col, return to SCAN.
//   - when cnt reaches DEBOUNCE_TICKS: key_valid=1 for that one clk, key_code=KEYMAP[col][row],
//     key_held=1, go HELD.
//   - DEBOUNCE_TICKS=1 accepts on the tick following entry.
// - HELD, on tick:
//   - col stays frozen; presses on other columns are ignored (no rollover).
//   - row[latched] still 0: stay.
//   - row==4'b1111: cnt=1, go RELEASE.
//   - other rows of the same column going low: ignored.
// - RELEASE, on tick:
//   - row==4'b1111: cnt++.
//   - any row low: cnt=0, return to HELD (bounce, no new strobe).
//   - cnt reaching DEBOUNCE_TICKS: key_held=0, rotate col, go SCAN.
// - Counter: 8-bit, saturates at DEBOUNCE_TICKS; never wraps.
// - tick held high for several clocks counts as several ticks; the source must guarantee a 1-cycle pulse.
// - Reset asserted mid-debounce or mid-hold: immediate return to reset values; no key_valid generated.
// - Key map, rows r0..r3 by columns c0..c3:
//   - r0: 1 2 3 A
//   - r1: 4 5 6 B
//   - r2: 7 8 9 C
//   - r3: E 0 F D
// STRUCTURE
// - keypad_pkg:
//   - typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} scan_state_t
//   - const KEYMAP[4][4] of logic [3:0]
//   - localparam COL_RESET = 4'b1110
// - Single always_ff for state/cnt/col/outputs; combinational next-state block.
// - Optional sub-module keypad_decode: (col_idx, row_onehot) -> {valid_onehot, hex}.
//   It is purely combinational and shared with the bench scoreboard.
// TESTING (DEBOUNCE_TICKS=3, tick every 10 clk)
// - Reset, no key: col cycles 1110,1101,1011,0111,1110 on successive ticks; key_valid never high.
// - Clean press of '5' (row=1101 while col=1101), hold 10 ticks, release:
//   - one key_valid, key_code=4'h5.
//   - key_held high from accept until 3 ticks after release.
//   - scanning resumes afterwards.
// - Bouncy press of 'D': row toggles low/high for 2 ticks, then stable.
//   - key_valid only after 3 consecutive stable ticks; key_code=4'hD; exactly one strobe.
// - Release bounce on '0': row 1111,0111,1111x3.
//   - returns to HELD once, then SCAN; no second key_valid.
// - Two rows low simultaneously on one column: no key_valid; col keeps rotating.
// - Reset pulse asserted during DEBOUNCE of '9': outputs return to reset values that cycle; no strobe.

Source files
------------

// File: rtl/keypad_scan_debounce_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map
// and the column-drive helpers used by the scanner and its bench.
package keypad_scan_debounce_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Indexed KEYMAP[col][row]; each inner list is one column read top to bottom.
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h4, 4'h7, 4'hE},
    '{4'h2, 4'h5, 4'h8, 4'h0},
    '{4'h3, 4'h6, 4'h9, 4'hF},
    '{4'hA, 4'hB, 4'hC, 4'hD}
  };

  function automatic logic [1:0] col_index(input logic [3:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    case (col)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce_if.sv
// Keypad-side signal bundle: scan strobe, row sense, column drive, key outputs
// and the scanner FSM state for observation.
interface keypad_scan_debounce_if;
  import keypad_scan_debounce_pkg::*;

  // tick is a 1-cycle strobe; key_valid is a 1-cycle pulse with no ready/back-pressure,
  // so the consumer must capture key_code in the same cycle key_valid is high.
  logic        tick;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  scan_state_t state;

  modport master (
    input  tick, row,
    output col, key_code, key_valid, key_held, state
  );

  modport slave (
    output tick, row,
    input  col, key_code, key_valid, key_held, state
  );

endinterface

// File: rtl/keypad_scan_debounce_decode.sv
// Combinational key decoder: flags a single active-low row and maps
// (column, row) to the key's hex code.
module keypad_scan_debounce_decode
  import keypad_scan_debounce_pkg::*;
(
  input  logic [1:0] col_idx,
  input  logic [3:0] row,
  output logic       one_low,
  output logic [3:0] hex
);

  logic [1:0] row_idx;

  // Any pattern other than exactly one low row (none, or ghosting) is not a key.
  always_comb begin
    one_low = 1'b1;
    row_idx = 2'd0;
    case (row)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
    hex = KEYMAP[col_idx][row_idx];
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad scanner: rotates an active-low column, debounces press and
// release on scan ticks, and strobes key_valid once per accepted press.
module keypad_scan_debounce
  import keypad_scan_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  keypad_scan_debounce_if.master kp
);

  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_TICKS);

  scan_state_t state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [3:0]  col_q, col_d, col_next;
  logic [3:0]  row_l_q, row_l_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        held_q, held_d;
  logic [1:0]  col_idx;
  logic        one_low;
  logic [3:0]  hex;

  assign col_idx  = col_index(col_q);
  assign col_next = {col_q[2:0], col_q[3]};
  // Saturating count keeps a long DEBOUNCE_TICKS from ever wrapping.
  assign cnt_inc  = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;

  keypad_scan_debounce_decode u_decode (
    .col_idx (col_idx),
    .row     (kp.row),
    .one_low (one_low),
    .hex     (hex)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_l_d = row_l_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    if (kp.tick) begin
      case (state_q)
        SCAN: begin
          if (one_low) begin
            row_l_d = kp.row;
            cnt_d   = 8'd1;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_next;
          end
        end
        DEBOUNCE: begin
          if (kp.row == row_l_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_MAX) begin
              valid_d = 1'b1;
              code_d  = hex;
              held_d  = 1'b1;
              state_d = HELD;
            end
          end else begin
            cnt_d   = 8'd0;
            col_d   = col_next;
            state_d = SCAN;
          end
        end
        // Column stays frozen while held, so other keys cannot roll over.
        HELD: begin
          if (kp.row == 4'b1111) begin
            cnt_d   = 8'd1;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (kp.row == 4'b1111) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_MAX) begin
              held_d  = 1'b0;
              col_d   = col_next;
              state_d = SCAN;
            end
          end else begin
            cnt_d   = 8'd0;
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SCAN;
      cnt_q   <= 8'd0;
      col_q   <= COL_RESET;
      row_l_q <= 4'b1111;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_l_q <= row_l_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign kp.col       = col_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;
  assign kp.state     = state_q;

endmodule
